// File: rtl/layer_compositor_pkg.sv
// ---------------------------------------------------------------------------
// layer_compositor_pkg
// Shared types and helpers for the layer compositor:
//   pixel_t           - packed RGB888 pixel, R in [23:16], G in [15:8], B in [7:0]
//   flash_state_t     - collision-flash FSM states
//   src_t             - which source won the per-pixel priority select
//   is_frame_boundary - first blanking cycle after the last active line
//   blend_pixel       - translucent wall over camera, per channel
//   tint_pixel        - 50/50 mix with a tint colour, per channel
// ---------------------------------------------------------------------------
package layer_compositor_pkg;

    typedef logic [23:0] pixel_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLASH = 1'b1
    } flash_state_t;

    // The frame boundary is a single cycle: column 0 of the first line below
    // the active area.
    function automatic logic is_frame_boundary(
        input logic [10:0] hcount,
        input logic [9:0]  vcount,
        input logic [9:0]  active_lines
    );
        return (hcount == 11'd0) && (vcount == active_lines);
    endfunction

    // ((2^s - 1) * w + p) >> s. The worst case (s = 3, both 8'hFF) is 2040,
    // so 11 bits always holds the sum. A shift of zero means an opaque wall.
    function automatic logic [7:0] blend_channel(
        input logic [7:0] w,
        input logic [7:0] p,
        input logic [1:0] shift
    );
        logic [10:0] acc;
        acc = ({3'b000, w} << shift) - {3'b000, w} + {3'b000, p};
        if (shift == 2'd0) begin
            return w;
        end else begin
            return 8'(acc >> shift);
        end
    endfunction

    function automatic pixel_t blend_pixel(
        input pixel_t     wall,
        input pixel_t     cam,
        input logic [1:0] shift
    );
        pixel_t res;
        res = 24'h000000;
        for (int c = 0; c < 3; c++) begin
            res[c*8 +: 8] = blend_channel(wall[c*8 +: 8], cam[c*8 +: 8], shift);
        end
        return res;
    endfunction

    // Halving both operands first keeps the sum within 8 bits (max 8'hFE).
    function automatic logic [7:0] tint_channel(
        input logic [7:0] p,
        input logic [7:0] c
    );
        return (p >> 3'd1) + (c >> 3'd1);
    endfunction

    function automatic pixel_t tint_pixel(
        input pixel_t p,
        input pixel_t tint
    );
        pixel_t res;
        res = 24'h000000;
        for (int c = 0; c < 3; c++) begin
            res[c*8 +: 8] = tint_channel(p[c*8 +: 8], tint[c*8 +: 8]);
        end
        return res;
    endfunction

endpackage

// File: rtl/layer_compositor_if.sv
// ---------------------------------------------------------------------------
// layer_compositor_if
// Pixel-stream bundle between the wall/collision renderer (master) and the
// compositor (slave).
//   hcount_in / vcount_in      - raster position of the incoming pixel
//   layer_valid_in             - per-overlay coverage flag, index 0 wins
//   layer_pixel_in             - overlay i occupies bits [i*24 +: 24]
//   is_wall_in / is_collision_in - renderer masks
//   pixel_in                   - camera pixel
//   pixel_out, hcount_out, vcount_out - composited pixel and aligned position
//   flashing_out               - collision flash active
//   collision_frame_out        - one-cycle pulse after a frame with a collision
// ---------------------------------------------------------------------------
interface layer_compositor_if #(
    parameter int NUM_LAYERS = 4
);
    logic [10:0]              hcount_in;
    logic [9:0]               vcount_in;
    logic [NUM_LAYERS-1:0]    layer_valid_in;
    logic [NUM_LAYERS*24-1:0] layer_pixel_in;
    logic                     is_wall_in;
    logic                     is_collision_in;
    logic [23:0]              pixel_in;
    logic [23:0]              pixel_out;
    logic [10:0]              hcount_out;
    logic [9:0]               vcount_out;
    logic                     flashing_out;
    logic                     collision_frame_out;

    modport master (
        output hcount_in, vcount_in, layer_valid_in, layer_pixel_in,
               is_wall_in, is_collision_in, pixel_in,
        input  pixel_out, hcount_out, vcount_out, flashing_out, collision_frame_out
    );

    modport slave (
        input  hcount_in, vcount_in, layer_valid_in, layer_pixel_in,
               is_wall_in, is_collision_in, pixel_in,
        output pixel_out, hcount_out, vcount_out, flashing_out, collision_frame_out
    );
endinterface

// File: rtl/layer_compositor_flash_controller.sv
// ---------------------------------------------------------------------------
// flash_controller
// Frame-level collision flash. Remembers whether the current frame contained
// a collision pixel and, at each frame boundary, starts, restarts, advances
// or ends the flash. The blink phase toggles every BLINK_FRAMES frames.
//   clk, rst_n        - pixel clock, synchronous active-low reset
//   hcount, vcount    - raster position of the pixel entering the pipeline
//   active, collision - pixel is in the active area / collision mask
//   flashing          - FSM is in FLASH (registered)
//   phase_on          - tint enabled for pixels entering the pipeline
//   frame_pulse       - one cycle, the cycle after a boundary ending a
//                       frame that contained a collision
// ---------------------------------------------------------------------------
module flash_controller
    import layer_compositor_pkg::*;
#(
    parameter int ACTIVE_LINES = 720,
    parameter int FLASH_FRAMES = 30,
    parameter int BLINK_FRAMES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        active,
    input  logic        collision,
    output logic        flashing,
    output logic        phase_on,
    output logic        frame_pulse
);
    localparam int FW = $clog2(FLASH_FRAMES + 1);
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FLASH_FRAMES - 1);
    localparam logic [FW-1:0] FRAME_ONE  = FW'(1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [BW-1:0] BLINK_ONE  = BW'(1);
    localparam logic [9:0]    LINES      = 10'(ACTIVE_LINES);

    flash_state_t   state_r,     state_s;
    logic [FW-1:0]  frame_cnt_r, frame_cnt_s;
    logic [BW-1:0]  blink_cnt_r, blink_cnt_s;
    logic           phase_on_r,  phase_on_s;
    logic           pulse_r,     pulse_s;
    logic           flashing_r,  flashing_s;
    logic           seen_r,      seen_s;
    logic           boundary_s;

    // Next-state logic for the FSM, counters and collision_seen flag.
    always_comb begin
        boundary_s  = is_frame_boundary(hcount, vcount, LINES);
        state_s     = state_r;
        frame_cnt_s = frame_cnt_r;
        blink_cnt_s = blink_cnt_r;
        phase_on_s  = phase_on_r;
        pulse_s     = 1'b0;

        // The boundary cycle itself is never active, so clearing wins safely.
        if (boundary_s) begin
            seen_s = 1'b0;
        end else begin
            seen_s = seen_r | (active & collision);
        end

        case (state_r)
            IDLE: begin
                if (boundary_s && seen_r) begin
                    state_s     = FLASH;
                    frame_cnt_s = '0;
                    blink_cnt_s = '0;
                    phase_on_s  = 1'b1;
                    pulse_s     = 1'b1;
                end else begin
                    phase_on_s  = 1'b0;
                end
            end
            FLASH: begin
                if (boundary_s && seen_r) begin
                    // A new collision restarts the whole effect.
                    frame_cnt_s = '0;
                    blink_cnt_s = '0;
                    phase_on_s  = 1'b1;
                    pulse_s     = 1'b1;
                end else if (boundary_s && (frame_cnt_r == FRAME_LAST)) begin
                    state_s     = IDLE;
                    frame_cnt_s = '0;
                    blink_cnt_s = '0;
                    phase_on_s  = 1'b0;
                end else if (boundary_s) begin
                    frame_cnt_s = frame_cnt_r + FRAME_ONE;
                    if (blink_cnt_r == BLINK_LAST) begin
                        blink_cnt_s = '0;
                        phase_on_s  = ~phase_on_r;
                    end else begin
                        blink_cnt_s = blink_cnt_r + BLINK_ONE;
                    end
                end else begin
                    state_s = FLASH;
                end
            end
            default: begin
                state_s     = IDLE;
                frame_cnt_s = '0;
                blink_cnt_s = '0;
                phase_on_s  = 1'b0;
            end
        endcase

        flashing_s = (state_s == FLASH);
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            frame_cnt_r <= '0;
            blink_cnt_r <= '0;
            phase_on_r  <= 1'b0;
            pulse_r     <= 1'b0;
            flashing_r  <= 1'b0;
            seen_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            frame_cnt_r <= frame_cnt_s;
            blink_cnt_r <= blink_cnt_s;
            phase_on_r  <= phase_on_s;
            pulse_r     <= pulse_s;
            flashing_r  <= flashing_s;
            seen_r      <= seen_s;
        end
    end

    assign flashing    = flashing_r;
    assign phase_on    = phase_on_r;
    assign frame_pulse = pulse_r;

endmodule

// File: rtl/layer_compositor.sv
// ---------------------------------------------------------------------------
// layer_compositor
// Two-stage pixel compositor. Stage 1 registers the priority winner
// (overlay > collision > wall > camera); stage 2 applies wall translucency
// and the collision-flash tint, blanks non-active pixels and registers the
// result. hcount/vcount travel alongside so they leave aligned.
//   clk_in    - pixel clock
//   rst_n_in  - synchronous active-low reset
//   lc        - pixel stream bundle (slave side)
// ---------------------------------------------------------------------------
module layer_compositor
    import layer_compositor_pkg::*;
#(
    parameter int     ACTIVE_H_PIXELS  = 1280,
    parameter int     ACTIVE_LINES     = 720,
    parameter int     NUM_LAYERS       = 4,
    parameter pixel_t COLLISION_COLOR  = 24'h800000,
    parameter pixel_t WALL_COLOR       = 24'hFF0080,
    parameter int     WALL_ALPHA_SHIFT = 0,
    parameter int     FLASH_FRAMES     = 30,
    parameter int     BLINK_FRAMES     = 4
) (
    input logic              clk_in,
    input logic              rst_n_in,
    layer_compositor_if.slave lc
);
    localparam logic [1:0] ALPHA_SHIFT = 2'(WALL_ALPHA_SHIFT);

    logic        active_s;
    logic        layer_hit_s;
    pixel_t      layer_pix_s;
    pixel_t      sel_pix_s;
    logic        sel_wall_s;
    logic        sel_tintable_s;
    logic        phase_on_s;
    logic        flashing_s;
    logic        frame_pulse_s;

    logic        s1_active_r;
    pixel_t      s1_pix_r;
    logic        s1_wall_r;
    logic        s1_tint_r;
    logic [10:0] s1_hcount_r;
    logic [9:0]  s1_vcount_r;

    pixel_t      base_s;
    pixel_t      final_s;

    assign active_s = (lc.hcount_in < 11'(ACTIVE_H_PIXELS)) &&
                      (lc.vcount_in < 10'(ACTIVE_LINES));

    // Lowest-index covered overlay; scanning downward lets index 0 overwrite.
    always_comb begin
        layer_hit_s = 1'b0;
        layer_pix_s = 24'h000000;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            layer_pix_s = lc.layer_valid_in[i] ? lc.layer_pixel_in[i*24 +: 24] : layer_pix_s;
            layer_hit_s = layer_hit_s | lc.layer_valid_in[i];
        end
    end

    // Priority select. For a wall the camera pixel is carried so stage 2 can
    // blend it; only wall and camera results may later be tinted.
    always_comb begin
        sel_pix_s      = lc.pixel_in;
        sel_wall_s     = 1'b0;
        sel_tintable_s = 1'b0;
        if (layer_hit_s) begin
            sel_pix_s = layer_pix_s;
        end else if (lc.is_collision_in) begin
            sel_pix_s = COLLISION_COLOR;
        end else if (lc.is_wall_in) begin
            sel_wall_s     = 1'b1;
            sel_tintable_s = 1'b1;
        end else begin
            sel_tintable_s = 1'b1;
        end
    end

    flash_controller #(
        .ACTIVE_LINES (ACTIVE_LINES),
        .FLASH_FRAMES (FLASH_FRAMES),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_flash (
        .clk         (clk_in),
        .rst_n       (rst_n_in),
        .hcount      (lc.hcount_in),
        .vcount      (lc.vcount_in),
        .active      (active_s),
        .collision   (lc.is_collision_in),
        .flashing    (flashing_s),
        .phase_on    (phase_on_s),
        .frame_pulse (frame_pulse_s)
    );

    // Stage 1 pipeline register; the tint decision samples the phase here so
    // a phase change takes effect on the pixel after the boundary.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            s1_active_r <= 1'b0;
            s1_pix_r    <= 24'h000000;
            s1_wall_r   <= 1'b0;
            s1_tint_r   <= 1'b0;
            s1_hcount_r <= 11'd0;
            s1_vcount_r <= 10'd0;
        end else begin
            s1_active_r <= active_s;
            s1_pix_r    <= sel_pix_s;
            s1_wall_r   <= sel_wall_s;
            s1_tint_r   <= sel_tintable_s & phase_on_s;
            s1_hcount_r <= lc.hcount_in;
            s1_vcount_r <= lc.vcount_in;
        end
    end

    // Stage 2 blend, tint and blanking.
    always_comb begin
        base_s  = s1_wall_r ? blend_pixel(WALL_COLOR, s1_pix_r, ALPHA_SHIFT) : s1_pix_r;
        final_s = s1_tint_r ? tint_pixel(base_s, COLLISION_COLOR) : base_s;
        if (!s1_active_r) begin
            final_s = 24'h000000;
        end else begin
            final_s = final_s;
        end
    end

    // Stage 2 output register.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            lc.pixel_out  <= 24'h000000;
            lc.hcount_out <= 11'd0;
            lc.vcount_out <= 10'd0;
        end else begin
            lc.pixel_out  <= final_s;
            lc.hcount_out <= s1_hcount_r;
            lc.vcount_out <= s1_vcount_r;
        end
    end

    assign lc.flashing_out        = flashing_s;
    assign lc.collision_frame_out = frame_pulse_s;

endmodule
